// File: rtl/sprite_pkg.sv
// sprite_pkg: sprite geometry constants and the line-fetcher FSM state type.
// No ports. Imported by the line buffer, the ROM interface and the fetcher top.
package sprite_pkg;
    localparam int SPRITE_W     = 30;
    localparam int SPRITE_H     = 45;
    localparam int SPRITE_DEPTH = 1350;
    localparam int PIX_W        = 5;
    localparam int ADDR_W       = 19;
    localparam int V_TOTAL      = 525;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
endpackage

// File: rtl/sprite_line_fetcher_if.sv
// sprite_line_fetcher_if: sprite ROM read bus.
// Signals: rom_addr (read address), rom_en (read enable), rom_data (palette index, one cycle after the address).
// Modports: master = fetcher side, slave = ROM side.
interface sprite_line_fetcher_if;
    import sprite_pkg::*;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [PIX_W-1:0]  rom_data;
    modport master (output rom_addr, rom_en, input rom_data);
    modport slave  (input rom_addr, rom_en, output rom_data);
endinterface

// File: rtl/sprite_line_buf.sv
// sprite_line_buf: 30 x 5-bit scanline register file, one synchronous write port and one asynchronous read port.
// Ports: Clk, we/waddr/wdata (write), raddr/rdata (read). Storage has no reset.
module sprite_line_buf
    import sprite_pkg::*;
(
    input  logic             Clk,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [4:0]       raddr,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] mem [SPRITE_W];

    always_ff @(posedge Clk)
        if (we && waddr < 5'(SPRITE_W)) mem[waddr] <= wdata;

    assign rdata = (raddr < 5'(SPRITE_W)) ? mem[raddr] : '0;
endmodule

// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher: fetches one 30-pixel sprite row from ROM during hblank and displays it on the next line.
// Ports: Clk, Reset_n (async active-low), line_start, DrawX/DrawY, player_x/player_y, flip,
//        rom (sprite_line_fetcher_if.master), pixel_index, pixel_valid, busy.
// Build option: define SPRITE_FLIP_EN to enable horizontal mirroring from the latched flip input.
module sprite_line_fetcher
    import sprite_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  line_start,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic [9:0]            player_x,
    input  logic [9:0]            player_y,
    input  logic                  flip,
    sprite_line_fetcher_if.master rom,
    output logic [PIX_W-1:0]      pixel_index,
    output logic                  pixel_valid,
    output logic                  busy
);
    state_t            state, state_nx;
    logic [4:0]        col, wr_col, rd_idx;
    logic              wr_en, line_valid, hit, in_range;
    logic [ADDR_W-1:0] base;
    logic [9:0]        px_q, target, row, bx;
    logic [PIX_W-1:0]  rd_data;

    assign target = (DrawY == 10'(V_TOTAL - 1)) ? '0 : DrawY + 10'd1;
    assign row    = target - player_y;
    assign hit    = row < 10'(SPRITE_H);

    // line_start always wins, which also gives abort-and-restart while busy
    always_comb begin
        state_nx = line_start ? (hit ? FETCH : IDLE)
                 : (state == FETCH) ? ((col == 5'(SPRITE_W - 1)) ? DRAIN : FETCH)
                 : IDLE;
    end

    assign busy         = state != IDLE;
    assign rom.rom_en   = state == FETCH;
    assign rom.rom_addr = rom.rom_en ? base + ADDR_W'(col) : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            col         <= '0;
            base        <= '0;
            px_q        <= '0;
            line_valid  <= 1'b0;
            wr_en       <= 1'b0;
            wr_col      <= '0;
            pixel_index <= '0;
            pixel_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            col         <= (state == FETCH && !line_start && col != 5'(SPRITE_W - 1)) ? col + 5'd1 : '0;
            // ROM data lags the address by one cycle, so the write trails the column counter
            wr_en       <= rom.rom_en;
            wr_col      <= col;
            line_valid  <= line_start ? 1'b0 : (state == DRAIN) ? 1'b1 : line_valid;
            pixel_valid <= in_range && rd_data != '0;
            pixel_index <= (in_range && rd_data != '0) ? rd_data : '0;
            if (line_start) begin
                // row*30 as (row<<5)-(row<<1), once per line
                base <= (ADDR_W'(row) << 5) - (ADDR_W'(row) << 1);
                px_q <= player_x;
            end
        end
    end

    assign bx       = DrawX - px_q;
    assign in_range = line_valid && bx < 10'(SPRITE_W);

`ifdef SPRITE_FLIP_EN
    logic flip_q;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) flip_q <= 1'b0;
        else if (line_start) flip_q <= flip;
    end
    assign rd_idx = flip_q ? 5'(10'(SPRITE_W - 1) - bx) : bx[4:0];
`else
    logic unused_flip;
    assign unused_flip = flip;
    assign rd_idx      = bx[4:0];
`endif

    sprite_line_buf u_buf (
        .Clk   (Clk),
        .we    (wr_en),
        .waddr (wr_col),
        .wdata (rom.rom_data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_sprite_line_fetcher.sv
// tb_sprite_line_fetcher: scoreboard bench for sprite_line_fetcher with a behavioural ROM and line model.
module tb_sprite_line_fetcher;
    logic       Clk = 0, Reset_n = 0, line_start = 0, flip = 0;
    logic [9:0] DrawX = 0, DrawY = 0, player_x = 0, player_y = 0;
    logic [4:0] pixel_index;
    logic       pixel_valid, busy;
    logic       drive_pix = 0, chk_pix = 0;

    sprite_line_fetcher_if rom_if ();

    sprite_line_fetcher dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .line_start  (line_start),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .player_x    (player_x),
        .player_y    (player_y),
        .flip        (flip),
        .rom         (rom_if),
        .pixel_index (pixel_index),
        .pixel_valid (pixel_valid),
        .busy        (busy)
    );

    int rom [1350];
    int addr_q [$];
    int pix_q [$];
    int n_pass = 0, n_total = 0;
    int m_row = 0, m_px = 0;
    bit m_valid = 0, m_flip = 0, m_hit = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_if.rom_data <= (rom_if.rom_addr < 1350) ? 5'(rom[rom_if.rom_addr]) : 5'd0;

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge Clk) chk_pix <= drive_pix;

    always @(negedge Clk) begin
        if (rom_if.rom_en) begin
            if (addr_q.size() == 0) check("rom_addr_unexpected", int'(rom_if.rom_addr), -1);
            else check("rom_addr", int'(rom_if.rom_addr), addr_q.pop_front());
        end
        if (chk_pix) begin
            if (pix_q.size() == 0) check("pixel_unexpected", int'({pixel_valid, pixel_index}), -1);
            else check("pixel", int'({pixel_valid, pixel_index}), pix_q.pop_front());
        end
    end

    function automatic int model_row(int y, int py);
        int t;
        t = (y == 524) ? 0 : y + 1;
        return (t - py + 1024) % 1024;
    endfunction

    // expected {valid, index} for a DrawX, from the sprite row last fetched
    function automatic int model_pix(int x);
        int bx, i, v;
        bx = x - m_px;
        if (!m_valid || bx < 0 || bx > 29) return 0;
        i = bx;
`ifdef SPRITE_FLIP_EN
        if (m_flip) i = 29 - bx;
`endif
        v = rom[m_row * 30 + i];
        return (v == 0) ? 0 : 32 + v;
    endfunction

    task automatic start_line(int y, int py, int px, bit fl);
        int row;
        row = model_row(y, py);
        DrawY = 10'(y); player_y = 10'(py); player_x = 10'(px); flip = fl; line_start = 1;
        @(posedge Clk);
        addr_q.delete();
        if (row < 45) for (int c = 0; c < 30; c++) addr_q.push_back(row * 30 + c);
        m_valid = 0; m_row = row; m_px = px; m_flip = fl; m_hit = (row < 45);
        #1 line_start = 0;
    endtask

    task automatic wait_done(string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
        check({name, "_busy_cycles"}, n, m_hit ? 31 : 0);
        check({name, "_addr_left"}, addr_q.size(), 0);
        m_valid = m_hit;
    endtask

    task automatic sweep(int lo, int hi);
        for (int x = lo; x <= hi; x++) begin
            if (x < 0 || x > 639) continue;
            DrawX = 10'(x); drive_pix = 1;
            pix_q.push_back(model_pix(x));
            @(posedge Clk); #1;
        end
        drive_pix = 0;
        @(posedge Clk); #1;
    endtask

    task automatic check_idle_outputs(string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_rom_en"}, int'(rom_if.rom_en), 0);
        check({name, "_rom_addr"}, int'(rom_if.rom_addr), 0);
        check({name, "_pixel_valid"}, int'(pixel_valid), 0);
        check({name, "_pixel_index"}, int'(pixel_index), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int py, px, y;
        #2 check_idle_outputs("reset");
        @(posedge Clk); #1 Reset_n = 1;
        @(posedge Clk); #1;

        for (int i = 0; i < 1350; i++) rom[i] = (i % 30 == 5) ? 0 : 7;
        start_line(99, 100, 200, 0); wait_done("row0"); sweep(195, 235);
        start_line(524, 0, 10, 0);   wait_done("wrap"); sweep(0, 45);
        start_line(143, 100, 400, 0); wait_done("row44"); sweep(395, 435);

        for (int i = 0; i < 1350; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31));
        start_line(120, 100, 200, 0); wait_done("hit"); sweep(198, 232);
        start_line(150, 100, 200, 0); wait_done("miss"); sweep(190, 240);
        start_line(610, 0, 615, 0);   wait_done("right_edge"); sweep(610, 639);

        start_line(120, 100, 50, 0);
        repeat (9) begin @(posedge Clk); #1; end
        start_line(130, 100, 300, 0); wait_done("abort"); sweep(295, 335);

        start_line(110, 100, 100, 0); wait_done("pre_reset"); sweep(98, 132);
        start_line(111, 100, 100, 0);
        repeat (14) begin @(posedge Clk); #1; end
        #2 Reset_n = 0;
        #1 check_idle_outputs("mid_reset");
        addr_q.delete(); m_valid = 0;
        @(posedge Clk); #1 Reset_n = 1;
        sweep(98, 132);
        start_line(111, 100, 100, 0); wait_done("post_reset"); sweep(98, 132);

`ifdef SPRITE_FLIP_EN
        rom[0] = 3;
        for (int i = 1; i < 30; i++) rom[i] = 7;
        start_line(99, 100, 300, 1); wait_done("flip"); sweep(298, 331);
`endif

        for (int k = 0; k < 20; k++) begin
            py = int'($urandom_range(0, 524));
            px = int'($urandom_range(0, 639));
            y = ($urandom_range(0, 1) == 1) ? (py + 524 + int'($urandom_range(0, 46))) % 525 : int'($urandom_range(0, 524));
            start_line(y, py, px, 1'($urandom_range(0, 1)));
            wait_done("rand");
            sweep(px - 2, px + 31);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sprite_line_fetcher.md
SPRITE_LINE_FETCHER -- requirements
Module: sprite_line_fetcher

Interface
REQ-001 Clk  in  1  system clock; all state advances on its rising edge.
REQ-002 Reset_n  in  1  asynchronous, active-low reset.
REQ-003 line_start  in  1  one-cycle pulse at start of horizontal blanking; requests fetch of the next scanline.
REQ-004 DrawX, DrawY  in  10 each  current raster position, DrawY range 0..524.
REQ-005 player_x, player_y  in  10 each  sprite top-left corner, sampled on line_start.
REQ-006 flip  in  1  horizontal mirror request, sampled on line_start (used only under SPRITE_FLIP_EN).
REQ-007 rom_addr  out  19  sprite ROM read address.
REQ-008 rom_en  out  1  ROM read enable (drives is_player).
REQ-009 rom_data  in  5  ROM palette index, valid one Clk after the address/enable.
REQ-010 pixel_index  out  5  palette index for the current DrawX.
REQ-011 pixel_valid  out  1  high when pixel_index is an opaque sprite pixel.
REQ-012 busy  out  1  high while a fetch is in progress.

Function
REQ-013 FSM states: IDLE, FETCH, DRAIN; reset state IDLE.
REQ-014 On line_start: target = DrawY+1, wrapping 524->0; row = target - player_y (10-bit unsigned).
REQ-015 Row < 45: go to FETCH, col=0, line_valid cleared; otherwise clear line_valid, stay/return IDLE, no ROM reads.
REQ-016 FETCH: issue rom_addr = row*30 + col, rom_en=1, col 0..29, one per cycle; col 29 -> DRAIN.
REQ-017 ROM data returned one cycle later is written to line buffer entry col-1 (entry 29 written in DRAIN).
REQ-018 DRAIN: rom_en=0, final write, line_valid=1, -> IDLE; total fetch = 31 cycles after line_start.
REQ-019 busy = 1 in FETCH and DRAIN only.
REQ-020 line_start while busy: abort current fetch, recompute row, restart at col=0; line_valid stays 0.
REQ-021 Address arithmetic 19-bit unsigned; maximum address 1349; never exceeds it.
REQ-022 Display: bx = DrawX - latched player_x; if line_valid and bx < 30, read buffer[bx]; registered, one-cycle latency from DrawX.
REQ-023 pixel_valid = in-range and index != 0 (index 0 is transparent); pixel_index forced 0 when pixel_valid=0.
REQ-024 Sprite partially off right edge (player_x > 610): columns past DrawX 639 are simply never displayed; no wrap to column 0.
REQ-025 Buffer written only during fetch; line_start is issued only at hblank start, so active-line reads never see writes.

Reset
REQ-026 Reset_n low: state IDLE, col=0, line_valid=0, rom_en=0, rom_addr=0, busy=0, pixel_index=0, pixel_valid=0, latched player_x/row/flip=0.
REQ-027 Reset asserted mid-fetch aborts immediately; the buffer contents are don't-care because line_valid=0.
REQ-028 First line_start after reset release is honoured normally.

Configuration
REQ-029 Macro SPRITE_FLIP_EN defined: when latched flip=1, buffer read index = 29 - bx (mirror); addressing unchanged.
REQ-030 SPRITE_FLIP_EN undefined: flip input ignored, no mirror logic; read index = bx.

Structure
REQ-031 Package sprite_pkg holds SPRITE_W=30, SPRITE_H=45, SPRITE_DEPTH=1350, PIX_W=5, ADDR_W=19, V_TOTAL=525, and the FSM state enum.
REQ-032 Sub-module sprite_line_buf: 30 x 5-bit register file, one synchronous write port, one asynchronous read port; no reset on storage.
REQ-033 Address generation uses a running base (row*30 computed once at line_start) plus col; no per-cycle multiplier.

Verification
REQ-034 player_y=100, line_start at DrawY=99 -> row 0, addresses 0..29 on consecutive cycles, busy 31 cycles, line_valid=1.
REQ-035 player_y=100, line_start at DrawY=150 -> row 51, rom_en never asserted, pixel_valid=0 across entire next line.
REQ-036 player_y=0, line_start at DrawY=524 -> target 0, row 0, address 0 first; line_start at DrawY=143, player_y=100 -> row 44, last address 1349.
REQ-037 ROM model returns 0 at col 5, 7 elsewhere; player_x=200 -> pixel_valid high DrawX 200..229 except 205, index 7, one-cycle latency.
REQ-038 Second line_start at fetch cycle 10 -> fetch restarts from col 0 with new row; Reset_n low at cycle 15 -> all outputs 0 asynchronously.
REQ-039 With SPRITE_FLIP_EN, flip=1, buffer entry 0=3, others 7 -> DrawX=player_x+29 shows index 3, player_x shows 7.
